// File: rtl/spell_mem_arbiter.sv
// Arbitrates a core request port and a Wishbone host port onto a single
// byte-wide memory port, with round-robin tie-break and an access watchdog.
module spell_mem_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clock,
    input  logic        reset,
    // core request port
    input  logic        c_select,
    input  logic [7:0]  c_addr,
    input  logic [7:0]  c_data_in,
    input  logic [1:0]  c_type,
    input  logic        c_write,
    output logic [7:0]  c_data_out,
    output logic        c_data_ready,
    // host Wishbone port
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    // memory port
    output logic        m_select,
    output logic [7:0]  m_addr,
    output logic [7:0]  m_data_in,
    output logic [1:0]  m_type,
    output logic        m_write,
    input  logic [7:0]  m_data_out,
    input  logic        m_data_ready,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, CORE, HOST, HOST_ACK} state_t;

    localparam logic [15:0] CNT_LAST = TIMEOUT_CYCLES - 16'd1;

    state_t      state_q, state_d;
    logic        m_select_q, m_select_d;
    logic [7:0]  m_addr_q, m_addr_d;
    logic [7:0]  m_data_in_q, m_data_in_d;
    logic [1:0]  m_type_q, m_type_d;
    logic        m_write_q, m_write_d;
    logic        o_wb_ack_q, o_wb_ack_d;
    logic [31:0] o_wb_data_q, o_wb_data_d;
    logic        err_timeout_q, err_timeout_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_host_q, last_host_d;

    logic host_req, host_in_win, grant_core, grant_host, timeout_hit, err_clear;

    assign host_req    = i_wb_cyc & i_wb_stb;
    assign host_in_win = (i_wb_addr[23:9] == 15'd0);
    // Core wins unless the host is also asking and the core went last.
    assign grant_core  = c_select & (~host_req | last_host_q);
    assign grant_host  = host_req & ~grant_core;
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign err_clear   = i_wb_we & (i_wb_addr == 32'h0000_0200) & i_wb_data[0];

    always_comb begin
        state_d       = state_q;
        m_select_d    = m_select_q;
        m_addr_d      = m_addr_q;
        m_data_in_d   = m_data_in_q;
        m_type_d      = m_type_q;
        m_write_d     = m_write_q;
        o_wb_ack_d    = 1'b0;
        o_wb_data_d   = o_wb_data_q;
        err_timeout_d = err_timeout_q;
        cnt_d         = cnt_q;
        last_host_d   = last_host_q;

        case (state_q)
            IDLE: begin
                if (grant_core) begin
                    state_d     = CORE;
                    m_select_d  = 1'b1;
                    m_addr_d    = c_addr;
                    m_data_in_d = c_data_in;
                    m_type_d    = c_type;
                    m_write_d   = c_write;
                    cnt_d       = 16'd0;
                    last_host_d = 1'b0;
                end else if (grant_host) begin
                    last_host_d = 1'b1;
                    if (host_in_win) begin
                        state_d     = HOST;
                        m_select_d  = 1'b1;
                        m_addr_d    = i_wb_addr[7:0];
                        m_data_in_d = i_wb_data[7:0];
                        m_type_d    = {1'b0, ~i_wb_addr[8]};
                        m_write_d   = i_wb_we;
                        cnt_d       = 16'd0;
                    end else begin
                        // Outside the memory window: ack without a memory cycle.
                        state_d     = HOST_ACK;
                        o_wb_ack_d  = 1'b1;
                        o_wb_data_d = 32'd0;
                        if (err_clear)
                            err_timeout_d = 1'b0;
                    end
                end
            end
            CORE: begin
                if (m_data_ready) begin
                    state_d    = IDLE;
                    m_select_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    m_select_d    = 1'b0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOST: begin
                if (m_data_ready) begin
                    state_d     = HOST_ACK;
                    m_select_d  = 1'b0;
                    o_wb_ack_d  = 1'b1;
                    o_wb_data_d = m_write_q ? 32'd0 : {24'd0, m_data_out};
                end else if (timeout_hit) begin
                    state_d       = HOST_ACK;
                    m_select_d    = 1'b0;
                    o_wb_ack_d    = 1'b1;
                    o_wb_data_d   = 32'd0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOST_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                m_select_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            m_select_q    <= 1'b0;
            m_addr_q      <= 8'd0;
            m_data_in_q   <= 8'd0;
            m_type_q      <= 2'd0;
            m_write_q     <= 1'b0;
            o_wb_ack_q    <= 1'b0;
            o_wb_data_q   <= 32'd0;
            err_timeout_q <= 1'b0;
            cnt_q         <= 16'd0;
            last_host_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            m_select_q    <= m_select_d;
            m_addr_q      <= m_addr_d;
            m_data_in_q   <= m_data_in_d;
            m_type_q      <= m_type_d;
            m_write_q     <= m_write_d;
            o_wb_ack_q    <= o_wb_ack_d;
            o_wb_data_q   <= o_wb_data_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
            last_host_q   <= last_host_d;
        end
    end

    // Core sees the memory response only while it owns the port.
    assign c_data_ready = (state_q == CORE) & m_data_ready;
    assign c_data_out   = (state_q == CORE) ? m_data_out : 8'd0;

    assign m_select    = m_select_q;
    assign m_addr      = m_addr_q;
    assign m_data_in   = m_data_in_q;
    assign m_type      = m_type_q;
    assign m_write     = m_write_q;
    assign o_wb_ack    = o_wb_ack_q;
    assign o_wb_data   = o_wb_data_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench for spell_mem_arbiter; the bench plays both requesters and the memory.
module tb_spell_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_select;
    logic [7:0]  c_addr, c_data_in;
    logic [1:0]  c_type;
    logic        c_write;
    logic [7:0]  c_data_out;
    logic        c_data_ready;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        m_select;
    logic [7:0]  m_addr, m_data_in;
    logic [1:0]  m_type;
    logic        m_write;
    logic [7:0]  m_data_out;
    logic        m_data_ready;
    logic        err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    spell_mem_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clock(clock), .reset(reset),
        .c_select(c_select), .c_addr(c_addr), .c_data_in(c_data_in), .c_type(c_type),
        .c_write(c_write), .c_data_out(c_data_out), .c_data_ready(c_data_ready),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .m_select(m_select), .m_addr(m_addr), .m_data_in(m_data_in), .m_type(m_type),
        .m_write(m_write), .m_data_out(m_data_out), .m_data_ready(m_data_ready),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr; i_wb_data = data;
    endtask

    task automatic host_drop();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (m_select !== 1'b0) begin n_fail++; $display("FAIL reset_m_select got %b want 0", m_select); end
        n_cmp++; if ({m_addr, m_data_in, m_type, m_write} !== 19'd0) begin n_fail++; $display("FAIL reset_m_bus got %h want 0", {m_addr, m_data_in, m_type, m_write}); end
        n_cmp++; if ({o_wb_ack, o_wb_data} !== 33'd0) begin n_fail++; $display("FAIL reset_wb got %h want 0", {o_wb_ack, o_wb_data}); end
        n_cmp++; if ({err_timeout, c_data_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {err_timeout, c_data_ready}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_core_read();
        c_select = 1'b1; c_type = 2'b01; c_addr = 8'h05; c_write = 1'b0; c_data_in = 8'h00;
        tick();
        n_cmp++; if ({m_select, m_addr, m_type, m_write} !== {1'b1, 8'h05, 2'b01, 1'b0}) begin n_fail++; $display("FAIL core_grant got %h want %h", {m_select, m_addr, m_type, m_write}, {1'b1, 8'h05, 2'b01, 1'b0}); end
        tick(); tick();
        n_cmp++; if (c_data_ready !== 1'b0) begin n_fail++; $display("FAIL core_early_ready got %b want 0", c_data_ready); end
        m_data_ready = 1'b1; m_data_out = 8'h3F; c_select = 1'b0;
        #1;
        n_cmp++; if ({c_data_ready, c_data_out} !== {1'b1, 8'h3F}) begin n_fail++; $display("FAIL core_ready got %h want %h", {c_data_ready, c_data_out}, {1'b1, 8'h3F}); end
        tick();
        m_data_ready = 1'b0;
        n_cmp++; if ({m_select, c_data_ready, c_data_out} !== 10'd0) begin n_fail++; $display("FAIL core_done got %h want 0", {m_select, c_data_ready, c_data_out}); end
        tick();
        n_cmp++; if (m_select !== 1'b0) begin n_fail++; $display("FAIL core_no_regrant got %b want 0", m_select); end
    endtask

    task automatic test_host_write();
        int acks = 0;
        host_req(1'b1, 32'h0000_01A3, 32'h0000_005A);
        tick();
        n_cmp++; if ({m_select, m_type, m_addr, m_write, m_data_in} !== {1'b1, 2'b00, 8'hA3, 1'b1, 8'h5A}) begin n_fail++; $display("FAIL hw_grant got %h want %h", {m_select, m_type, m_addr, m_write, m_data_in}, {1'b1, 2'b00, 8'hA3, 1'b1, 8'h5A}); end
        n_cmp++; if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL hw_early_ack got %b want 0", o_wb_ack); end
        tick();
        m_data_ready = 1'b1; m_data_out = 8'hEE;
        tick();
        m_data_ready = 1'b0;
        n_cmp++; if ({o_wb_ack, m_select, o_wb_data} !== {1'b1, 1'b0, 32'd0}) begin n_fail++; $display("FAIL hw_ack got %h want %h", {o_wb_ack, m_select, o_wb_data}, {1'b1, 1'b0, 32'd0}); end
        host_drop();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_wb_ack === 1'b1) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL hw_single_ack extra acks got %0d want 0", acks); end
    endtask

    task automatic test_host_read();
        host_req(1'b0, 32'h0000_00C7, 32'h0000_0000);
        tick();
        n_cmp++; if ({m_select, m_type, m_addr, m_write} !== {1'b1, 2'b01, 8'hC7, 1'b0}) begin n_fail++; $display("FAIL hr_grant got %h want %h", {m_select, m_type, m_addr, m_write}, {1'b1, 2'b01, 8'hC7, 1'b0}); end
        m_data_ready = 1'b1; m_data_out = 8'h9E;
        tick();
        m_data_ready = 1'b0;
        host_drop();
        n_cmp++; if ({o_wb_ack, o_wb_data} !== {1'b1, 32'h0000_009E}) begin n_fail++; $display("FAIL hr_data got %h want %h", {o_wb_ack, o_wb_data}, {1'b1, 32'h0000_009E}); end
        tick();
    endtask

    task automatic test_back_to_back();
        reset = 1'b1; tick(); reset = 1'b0;
        c_select = 1'b1; c_addr = 8'h11; c_type = 2'b00; c_write = 1'b0;
        host_req(1'b0, 32'h0000_0022, 32'h0);
        for (int r = 0; r < 2; r++) begin
            tick();
            n_cmp++; if ({m_select, m_addr} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL tie_core_%0d got %h want %h", r, {m_select, m_addr}, {1'b1, 8'h11}); end
            m_data_ready = 1'b1; m_data_out = 8'h10;
            tick();
            m_data_ready = 1'b0;
            tick();
            n_cmp++; if ({m_select, m_addr, m_type} !== {1'b1, 8'h22, 2'b01}) begin n_fail++; $display("FAIL tie_host_%0d got %h want %h", r, {m_select, m_addr, m_type}, {1'b1, 8'h22, 2'b01}); end
            m_data_ready = 1'b1; m_data_out = 8'h44;
            tick();
            m_data_ready = 1'b0;
            n_cmp++; if ({o_wb_ack, m_select, o_wb_data} !== {1'b1, 1'b0, 32'h44}) begin n_fail++; $display("FAIL tie_ack_%0d got %h want %h", r, {o_wb_ack, m_select, o_wb_data}, {1'b1, 1'b0, 32'h44}); end
            tick();
            n_cmp++; if ({o_wb_ack, m_select} !== 2'b00) begin n_fail++; $display("FAIL tie_idle_%0d got %b want 00", r, {o_wb_ack, m_select}); end
        end
        c_select = 1'b0; host_drop();
        tick();
    endtask

    task automatic test_out_of_window();
        int waited = 0;
        int sel_seen = 0;
        host_req(1'b0, 32'h0000_0400, 32'h0);
        while (o_wb_ack !== 1'b1 && waited < 4) begin
            tick();
            waited++;
            if (m_select === 1'b1) sel_seen++;
        end
        host_drop();
        n_cmp++; if (waited > 2 || o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL oow_ack_latency got %0d cycles ack=%b want <=2 ack=1", waited, o_wb_ack); end
        n_cmp++; if (o_wb_data !== 32'd0) begin n_fail++; $display("FAIL oow_data got %h want 0", o_wb_data); end
        tick();
        if (m_select === 1'b1) sel_seen++;
        n_cmp++; if (sel_seen !== 0 || o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL oow_no_mem sel=%0d ack=%b want 0 0", sel_seen, o_wb_ack); end
    endtask

    task automatic test_timeout();
        int bad = 0;
        c_select = 1'b1; c_addr = 8'h33; c_write = 1'b0;
        tick();
        c_select = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (m_select !== 1'b1 || err_timeout !== 1'b0) bad++;
            tick();
        end
        if (m_select !== 1'b1 || err_timeout !== 1'b0) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL to_hold got %0d bad cycles want 0", bad); end
        tick();
        n_cmp++; if ({m_select, err_timeout, o_wb_ack} !== 3'b010) begin n_fail++; $display("FAIL to_core_abort got %b want 010", {m_select, err_timeout, o_wb_ack}); end
        tick();
        host_req(1'b0, 32'h0000_0105, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (m_select !== 1'b1) begin n_fail++; $display("FAIL to_host_hold got %b want 1", m_select); end
        tick();
        host_drop();
        n_cmp++; if ({o_wb_ack, m_select, err_timeout, o_wb_data} !== {3'b101, 32'd0}) begin n_fail++; $display("FAIL to_host_abort got %h want %h", {o_wb_ack, m_select, err_timeout, o_wb_data}, {3'b101, 32'd0}); end
        tick();
        host_req(1'b1, 32'h0000_0200, 32'h0000_0000);
        tick();
        host_drop();
        n_cmp++; if ({o_wb_ack, err_timeout} !== 2'b11) begin n_fail++; $display("FAIL to_noclear got %b want 11", {o_wb_ack, err_timeout}); end
        tick();
        host_req(1'b1, 32'h0000_0200, 32'h0000_0001);
        tick();
        host_drop();
        n_cmp++; if ({o_wb_ack, err_timeout, m_select} !== 3'b100) begin n_fail++; $display("FAIL to_clear got %b want 100", {o_wb_ack, err_timeout, m_select}); end
        tick();
        // response landing exactly on the abort edge completes normally
        c_select = 1'b1; c_addr = 8'h44;
        tick();
        c_select = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        m_data_ready = 1'b1; m_data_out = 8'h77;
        #1;
        n_cmp++; if ({c_data_ready, c_data_out} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL to_edge_ready got %h want %h", {c_data_ready, c_data_out}, {1'b1, 8'h77}); end
        tick();
        m_data_ready = 1'b0;
        n_cmp++; if ({m_select, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL to_edge_noerr got %b want 00", {m_select, err_timeout}); end
        tick();
    endtask

    task automatic test_reset_mid();
        host_req(1'b0, 32'h0000_0101, 32'h0);
        tick();
        n_cmp++; if (m_select !== 1'b1) begin n_fail++; $display("FAIL rm_grant got %b want 1", m_select); end
        tick();
        reset = 1'b1; m_data_ready = 1'b1; m_data_out = 8'h5C;
        tick();
        n_cmp++; if ({m_select, o_wb_ack, c_data_ready} !== 3'b000) begin n_fail++; $display("FAIL rm_drop got %b want 000", {m_select, o_wb_ack, c_data_ready}); end
        reset = 1'b0; m_data_ready = 1'b0; host_drop();
        tick();
        n_cmp++; if ({m_select, o_wb_ack, o_wb_data} !== 34'd0) begin n_fail++; $display("FAIL rm_idle got %h want 0", {m_select, o_wb_ack, o_wb_data}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        c_select = 1'b0; c_addr = 8'h0; c_data_in = 8'h0; c_type = 2'b00; c_write = 1'b0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_addr = 32'h0; i_wb_data = 32'h0;
        m_data_out = 8'h0; m_data_ready = 1'b0;
        test_reset();
        test_core_read();
        test_host_write();
        test_host_read();
        test_back_to_back();
        test_out_of_window();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spell_mem_arbiter.md
SPELL_MEM_ARBITER -- requirements
Module: spell_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1024, the number of cycles a granted access may wait for m_data_ready before it is aborted.
REQ-002 SHALL have port clock  in  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high.
REQ-004 SHALL have core-side ports c_select in 1, c_addr in 8, c_data_in in 8, c_type in 2, c_write in 1, c_data_out out 8, c_data_ready out 1; this is the core's memory request port.
REQ-005 SHALL have host-side Wishbone ports i_wb_cyc in 1, i_wb_stb in 1, i_wb_we in 1, i_wb_addr in 32, i_wb_data in 32, o_wb_ack out 1, o_wb_data out 32.
REQ-006 SHALL have memory-side ports m_select out 1, m_addr out 8, m_data_in out 8, m_type out 2, m_write out 1, m_data_out in 8, m_data_ready in 1.
REQ-007 SHALL have port err_timeout  out  1  sticky abort flag.
REQ-008 SHALL use memory type encoding 2'b00 = data and 2'b01 = code; other values are invalid.

Function
REQ-009 SHALL implement FSM states IDLE, CORE, HOST, HOST_ACK.
REQ-010 SHALL treat a host request as i_wb_cyc & i_wb_stb with i_wb_addr[23:9] == 0; i_wb_addr[8] selects data (1) or code (0), and i_wb_addr[7:0] is the byte address.
REQ-011 SHALL, for a host request outside that window, go IDLE->HOST_ACK without touching memory, returning o_wb_data = 0 and ignoring writes.
REQ-012 SHALL, in IDLE with one request pending, grant it at the next edge (CORE or HOST).
REQ-013 SHALL, in IDLE with both requests pending, grant the requester not granted last; last_grant resets to "host", so the core wins the first tie.
REQ-014 SHALL register m_addr, m_data_in, m_type and m_write at grant and hold them stable with m_select = 1 until m_data_ready is sampled or the access is aborted.
REQ-015 SHALL drive a host grant as m_type = {1'b0, ~i_wb_addr[8]}, m_write = i_wb_we, m_data_in = i_wb_data[7:0].
REQ-016 SHALL, in CORE, pass m_data_ready to c_data_ready and m_data_out to c_data_out combinationally; outside CORE, c_data_ready = 0 and c_data_out = 0.
REQ-017 SHALL, on sampling m_data_ready in CORE, clear m_select and return to IDLE at that same edge.
REQ-018 SHALL, on sampling m_data_ready in HOST, clear m_select, register o_wb_data = {24'b0, m_data_out} (0 on writes), pulse o_wb_ack = 1 for exactly one cycle, and enter HOST_ACK.
REQ-019 SHALL leave HOST_ACK for IDLE after one cycle; a new grant is therefore never issued on the cycle o_wb_ack is high.
REQ-020 SHALL ignore c_select deasserting mid-access: the memory access completes and the result is discarded.
REQ-021 SHALL count cycles with m_select = 1 in a 16-bit counter cleared at each grant; when the count equals TIMEOUT_CYCLES-1 without m_data_ready, the access SHALL be aborted at that edge.
REQ-022 SHALL handle an abort as: m_select cleared, err_timeout set, state -> IDLE for core or HOST_ACK for host (o_wb_ack pulsed, o_wb_data = 0).
REQ-023 SHALL, when m_data_ready arrives on the abort edge, complete normally and leave err_timeout unchanged.
REQ-024 SHALL clear err_timeout only on a host write to address 0x200 with i_wb_data[0] = 1; that access is acked via HOST_ACK.
REQ-025 SHALL never assert m_select in IDLE or HOST_ACK.

Reset
REQ-026 SHALL, on reset, set state = IDLE, m_select = 0, m_write = 0, m_addr = 0, m_data_in = 0, m_type = 0, o_wb_ack = 0, o_wb_data = 0, err_timeout = 0, counter = 0, last_grant = host.
REQ-027 SHALL, on reset asserted mid-access, drop m_select the next cycle and issue no ack or ready pulse for the interrupted access.

Verification
REQ-028 Core read: c_select = 1, c_type = 01, c_addr = 0x05, memory returns 0x3F after 3 cycles -> m_addr = 0x05; c_data_ready pulses 1 cycle with c_data_out = 0x3F; m_select = 0 on the next cycle.
REQ-029 Host write: i_wb_addr = 0x1A3, i_wb_data = 0x5A, we = 1 -> m_type = 00, m_addr = 0xA3, m_write = 1, m_data_in = 0x5A; single o_wb_ack pulse.
REQ-030 Tie: core and host requesting from reset -> core granted first, host second; repeat both continuously -> grants alternate.
REQ-031 Out-of-window: i_wb_addr = 0x400 read -> o_wb_ack after 2 cycles, o_wb_data = 0, m_select stays 0.
REQ-032 Timeout: TIMEOUT_CYCLES = 8, m_data_ready held 0 -> abort at the 8th m_select cycle, err_timeout = 1; host write 0x200 <= 1 clears it.
REQ-033 Reset mid-access: assert reset during HOST with m_select = 1 -> m_select = 0 and o_wb_ack = 0 next cycle; state IDLE.
